// File: rtl/bundler_ctrl.sv
// bundler_ctrl: sequencing controller that clears the bundler set, streams N hypervectors into it, binarizes, and presents the result
// Ports: clk_i/rst_i (async active-high); start_i + num_items_i begin a job; abort_i cancels it;
//   hv_valid_i/hv_ready_o upstream handshake; bundle_valid_o/bundle_clr_o/bundle_binarize_o drive the bundler set;
//   res_valid_o/res_ready_i downstream handshake; busy_o, items_o, sat_o status.
// Optional: define BUNDLER_CTRL_PERF_EN to add perf_stall_o, a saturating stall-cycle counter.
module bundler_ctrl #(
  parameter int CounterWidth   = 8,
  parameter int ItemCountWidth = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic [ItemCountWidth-1:0] num_items_i,
  input  logic                      abort_i,
  input  logic                      hv_valid_i,
  output logic                      hv_ready_o,
  output logic                      bundle_valid_o,
  output logic                      bundle_clr_o,
  output logic                      bundle_binarize_o,
  output logic                      res_valid_o,
  input  logic                      res_ready_i,
  output logic                      busy_o,
  output logic [ItemCountWidth-1:0] items_o,
  output logic                      sat_o
`ifdef BUNDLER_CTRL_PERF_EN
  ,
  output logic [31:0]               perf_stall_o
`endif
);
  localparam logic [63:0] SafeMax = (64'd1 << (CounterWidth - 1)) - 64'd1;
  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, BINARIZE, OUTPUT} state_e;
  state_e state_q, state_d;
  logic [ItemCountWidth-1:0] rem_q, rem_d, items_q, items_d;
  logic sat_q, sat_d, clr_q, clr_d, bin_q, bin_d, res_q, res_d, busy_q, busy_d;
  logic hs, kill;
  assign hv_ready_o        = state_q == ACCUM;
  assign bundle_valid_o    = hv_valid_i & hv_ready_o;
  assign hs                = bundle_valid_o;
  assign kill              = abort_i & (state_q != IDLE);
  assign bundle_clr_o      = clr_q;
  assign bundle_binarize_o = bin_q;
  assign res_valid_o       = res_q;
  assign busy_o            = busy_q;
  assign items_o           = items_q;
  assign sat_o             = sat_q;
  // A handshake still counts when it coincides with an abort; only the state transition is overridden.
  always_comb begin
    state_d = state_q;
    rem_d   = hs ? rem_q - 1'b1 : rem_q;
    items_d = hs ? items_q + 1'b1 : items_q;
    sat_d   = sat_q | (hs & (64'(items_q) >= SafeMax));
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = CLEAR;
        rem_d   = num_items_i;
        items_d = '0;
        sat_d   = 1'b0;
      end
      CLEAR:    state_d = (rem_q != '0) ? ACCUM : BINARIZE;
      ACCUM:    state_d = (hs && rem_q == ItemCountWidth'(1)) ? BINARIZE : ACCUM;
      BINARIZE: state_d = OUTPUT;
      OUTPUT:   state_d = res_ready_i ? IDLE : OUTPUT;
      default:  state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
    clr_d  = kill | (state_d == CLEAR);
    bin_d  = state_d == BINARIZE;
    res_d  = state_d == OUTPUT;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      items_q <= '0;
      sat_q   <= 1'b0;
      clr_q   <= 1'b0;
      bin_q   <= 1'b0;
      res_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      items_q <= items_d;
      sat_q   <= sat_d;
      clr_q   <= clr_d;
      bin_q   <= bin_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
    end
  end
`ifdef BUNDLER_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall;
  assign stall        = (state_q == ACCUM && !hv_valid_i) || (state_q == OUTPUT && !res_ready_i);
  assign perf_stall_o = perf_q;
  always_comb perf_d = (state_q == IDLE && start_i) ? '0 : (stall && perf_q != '1) ? perf_q + 1'b1 : perf_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) perf_q <= '0;
    else perf_q <= perf_d;
  end
`endif
endmodule

// File: tb/tb_bundler_ctrl.sv
// tb_bundler_ctrl: randomized and directed checks of bundler_ctrl against a job-level reference model
module tb_bundler_ctrl;
  localparam int IW = 16;
  localparam int SAFE = 127;
  localparam int P_IDLE = 0, P_CLR = 1, P_ACC = 2, P_BIN = 3, P_OUT = 4;
  logic clk = 0, rst = 1, start = 0, abort = 0, hv_valid = 0, res_ready = 0;
  logic [IW-1:0] num = '0;
  logic hv_ready, bvalid, bclr, bbin, rvalid, busy, sat;
  logic [IW-1:0] items;
`ifdef BUNDLER_CTRL_PERF_EN
  logic [31:0] perf;
`endif
  bundler_ctrl #(.CounterWidth(8), .ItemCountWidth(IW)) dut (
`ifdef BUNDLER_CTRL_PERF_EN
    .perf_stall_o(perf),
`endif
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_items_i(num), .abort_i(abort),
    .hv_valid_i(hv_valid), .hv_ready_o(hv_ready), .bundle_valid_o(bvalid),
    .bundle_clr_o(bclr), .bundle_binarize_o(bbin), .res_valid_o(rvalid),
    .res_ready_i(res_ready), .busy_o(busy), .items_o(items), .sat_o(sat)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Job-level model: phase of the job, requested length, items taken, sticky saturation, pending abort clear.
  typedef struct {
    int ph;
    int n;
    int got;
    bit sat;
    bit ab;
    longint perf;
  } mdl_t;
  mdl_t m;
  function automatic longint bump(input longint v);
    return (v < 64'hFFFF_FFFF) ? v + 1 : v;
  endfunction
  function automatic mdl_t nxt(input mdl_t c);
    mdl_t x;
    x = c;
    x.ab = 0;
    case (c.ph)
      P_IDLE: if (start) begin
        x.ph = P_CLR; x.n = int'(num); x.got = 0; x.sat = 0; x.perf = 0;
      end
      P_CLR: x.ph = (c.n == 0) ? P_BIN : P_ACC;
      P_ACC: if (hv_valid) begin
        x.got = c.got + 1;
        if (x.got > SAFE) x.sat = 1;
        if (x.got == c.n) x.ph = P_BIN;
      end else x.perf = bump(c.perf);
      P_BIN: x.ph = P_OUT;
      P_OUT: if (res_ready) x.ph = P_IDLE; else x.perf = bump(c.perf);
      default: x.ph = P_IDLE;
    endcase
    if (abort && c.ph != P_IDLE) begin
      x.ph = P_IDLE;
      x.ab = 1;
    end
    return x;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{P_IDLE, 0, 0, 1'b0, 1'b0, 64'd0};
    else m <= nxt(m);
  end
  always @(negedge clk) begin
    chk("clr", bclr, m.ph == P_CLR || m.ab);
    chk("hv_ready", hv_ready, m.ph == P_ACC);
    chk("bundle_valid", bvalid, m.ph == P_ACC && hv_valid);
    chk("binarize", bbin, m.ph == P_BIN);
    chk("res_valid", rvalid, m.ph == P_OUT);
    chk("busy", busy, m.ph != P_IDLE);
    chk("items", items, m.got);
    chk("sat", sat, m.sat);
`ifdef BUNDLER_CTRL_PERF_EN
    chk("perf", perf, m.perf);
`endif
  end
  int vcnt, clr_cnt, bin_at, rv_at, sat_hs;
  task automatic sync();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input int n);
    num = IW'(n);
    start = 1;
    sync();
    start = 0;
  endtask
  task automatic run(input int ncyc, input bit tog, input int ab_at);
    vcnt = 0; clr_cnt = 0; bin_at = -1; rv_at = -1; sat_hs = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (sat && sat_hs < 0) sat_hs = vcnt;
      if (bvalid) vcnt++;
      if (bclr) clr_cnt++;
      if (bbin && bin_at < 0) bin_at = k;
      if (rvalid && rv_at < 0) rv_at = k;
      sync();
      if (tog) hv_valid = ~hv_valid;
      abort = (k + 1 == ab_at);
    end
    abort = 0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int w, rvcnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_items", items, 0);
    sync();
    rst = 0;
    hv_valid = 1; res_ready = 1;
    go(5);
    run(8, 0, 0);
    chk("basic_clr", clr_cnt, 1);
    chk("basic_pulses", vcnt, 5);
    chk("basic_bin_cycle", bin_at, 7);
    chk("basic_rv_cycle", rv_at, 8);
    @(negedge clk);
    chk("basic_busy", busy, 0);
    chk("basic_items", items, 5);
    chk("basic_sat", sat, 0);
    sync();
    hv_valid = 0;
    go(4);
    run(10, 1, 0);
    chk("gap_pulses", vcnt, 4);
    chk("gap_bin_cycle", bin_at, 9);
    chk("gap_rv_cycle", rv_at, 10);
`ifdef BUNDLER_CTRL_PERF_EN
    chk("gap_stalls", perf, 3);
`endif
    hv_valid = 1; res_ready = 0;
    go(2);
    w = 0;
    while (!rvalid && w < 20) begin sync(); w++; end
    chk("bp_reach_output", w < 20, 1);
    rvcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rvalid) rvcnt++;
      sync();
      num = 7;
      start = (k == 2);
    end
    start = 0;
    chk("bp_held", rvcnt, 10);
    res_ready = 1;
    @(negedge clk);
    chk("bp_still_valid", rvalid, 1);
    sync();
    @(negedge clk);
    chk("bp_idle", busy, 0);
    chk("bp_items", items, 2);
    sync();
    go(0);
    run(4, 0, 0);
    chk("zero_clr", clr_cnt, 1);
    chk("zero_bin_cycle", bin_at, 2);
    chk("zero_rv_cycle", rv_at, 3);
    chk("zero_pulses", vcnt, 0);
    @(negedge clk);
    chk("zero_items", items, 0);
    sync();
    go(130);
    run(135, 0, 0);
    chk("sat_at_handshake", sat_hs, 128);
    chk("sat_pulses", vcnt, 130);
    chk("sat_rv_cycle", rv_at, 133);
    @(negedge clk);
    chk("sat_sticky", sat, 1);
    sync();
    go(1);
    @(negedge clk);
    chk("sat_cleared", sat, 0);
    sync();
    run(4, 0, 0);
    go(10);
    run(8, 0, 4);
    chk("abort_pulses", vcnt, 3);
    chk("abort_clr", clr_cnt, 2);
    chk("abort_no_bin", bin_at, -1);
    chk("abort_no_rv", rv_at, -1);
    @(negedge clk);
    chk("abort_items", items, 3);
    chk("abort_idle", busy, 0);
    sync();
    go(5);
    repeat (2) sync();
    #2 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", hv_ready, 0);
    chk("arst_valid", bvalid, 0);
    chk("arst_items", items, 0);
    chk("arst_clr", bclr, 0);
    @(negedge clk);
    #2 rst = 0;
    sync();
    go(2);
    run(6, 0, 0);
    chk("arst_job_pulses", vcnt, 2);
    chk("arst_job_bin", bin_at, 4);
    chk("arst_job_rv", rv_at, 5);
    @(negedge clk);
    chk("arst_job_items", items, 2);
    sync();
    for (int i = 0; i < 800; i++) begin
      hv_valid = $urandom_range(0, 3) != 0;
      res_ready = $urandom_range(0, 2) != 0;
      abort = $urandom_range(0, 40) == 0;
      start = $urandom_range(0, 3) == 0;
      num = IW'($urandom_range(0, 6));
      sync();
    end
    start = 0; abort = 0; res_ready = 1; hv_valid = 1;
    repeat (20) sync();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bundler_ctrl.md
Name: bundler_ctrl

Overview:
- Sequencing controller for the bundler set.
- Accepts a bundling job of N hypervectors and clears the bundler counters.
- Streams the N hypervectors into the bundler set over a valid/ready handshake, then issues the binarize strobe.
- Presents a result-valid handshake to the downstream consumer (item memory / associative search). Sits between the encoder front end and the bundler set.

Parameters:
- CounterWidth, 8, width of each signed bundler counter; sets the overflow-safe item limit SafeMax = 2^(CounterWidth-1)-1.
- ItemCountWidth, 16, width of the job length field and internal item counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- start_i  in  1  job start strobe; sampled in IDLE only.
- num_items_i  in  ItemCountWidth  number of hypervectors in the job; sampled with start_i.
- abort_i  in  1  synchronous abort of the current job.
- hv_valid_i  in  1  upstream hypervector valid.
- hv_ready_o  out  1  upstream hypervector ready.
- bundle_valid_o  out  1  drives bundler set valid_i.
- bundle_clr_o  out  1  drives bundler set clr_i.
- bundle_binarize_o  out  1  drives bundler set binarize_i.
- res_valid_o  out  1  bundled result available.
- res_ready_i  in  1  downstream accepts result.
- busy_o  out  1  high in any state except IDLE.
- items_o  out  ItemCountWidth  items accepted so far in the current job.
- sat_o  out  1  sticky: job exceeded SafeMax items; counters may have saturated.

Behaviour:
- Reset (rst_i high, async):
  - State goes to IDLE.
  - All outputs 0; items_o = 0; sat_o = 0.
  - Internal remaining-count register = 0.
- States: IDLE, CLEAR, ACCUM, BINARIZE, OUTPUT.
- IDLE:
  - start_i = 1: latch num_items_i into remaining, items_o := 0, sat_o := 0, go to CLEAR.
  - start_i outside IDLE is ignored.
- CLEAR:
  - bundle_clr_o = 1 for exactly one cycle.
  - Next state ACCUM if remaining != 0, else BINARIZE (zero-item job yields an all-zero bundle).
- ACCUM:
  - hv_ready_o = 1.
  - bundle_valid_o = hv_valid_i & hv_ready_o (combinational, same cycle as the handshake).
  - Each handshake: remaining -= 1, items_o += 1.
  - If items_o + 1 > SafeMax at a handshake, sat_o := 1.
  - Handshake with remaining == 1: go to BINARIZE next cycle; hv_ready_o drops that next cycle.
- BINARIZE: bundle_binarize_o = 1 for exactly one cycle, then go to OUTPUT.
- OUTPUT:
  - res_valid_o = 1, held until res_ready_i = 1.
  - res_valid_o must not drop before acceptance.
  - On acceptance, go to IDLE next cycle.
  - Bundler counters are not cleared here; the result stays readable until the next job's CLEAR.
- abort_i (any non-IDLE state):
  - Next cycle bundle_clr_o = 1 for one cycle, then IDLE.
  - items_o retains its value; sat_o retains its value; res_valid_o deasserts immediately.
  - abort_i has priority over every other transition.
  - abort_i in IDLE has no effect.
- Simultaneous abort_i and final ACCUM handshake: abort wins. The bundle_valid_o pulse for that cycle still occurs; counters are cleared the following cycle.
- items_o does not wrap: num_items_i <= 2^ItemCountWidth-1 by construction.
- Control outputs are registered except hv_ready_o and bundle_valid_o, which are decoded from state (and hv_valid_i for bundle_valid_o).
- Minimum job latency: start → res_valid_o = N + 3 cycles with hv_valid_i constantly high.

Optional Feature:
- Macro: BUNDLER_CTRL_PERF_EN.
- Defined:
  - Adds output perf_stall_o [31:0], which counts cycles in ACCUM with hv_valid_i = 0 plus cycles in OUTPUT with res_ready_i = 0.
  - Cleared on job start; saturates at 2^32-1; reset to 0.
- Undefined: port and counter absent; no other behaviour change.

Test Plan:
- Basic job: start_i with num_items_i = 5, hv_valid_i held high, res_ready_i high → clr pulse at cycle 1; exactly 5 bundle_valid_o pulses; binarize at cycle 7; res_valid_o at cycle 8; items_o = 5, sat_o = 0, busy_o low at cycle 9.
- Upstream gaps: num_items_i = 4, hv_valid_i toggling 1,0,1,0,... → exactly 4 bundle_valid_o pulses, each coincident with hv_valid_i = 1; binarize after the 4th handshake; stall count 3 with BUNDLER_CTRL_PERF_EN.
- Backpressure: res_ready_i low 10 cycles in OUTPUT → res_valid_o stays high all 10 cycles; IDLE one cycle after res_ready_i rises; a start_i pulse during OUTPUT is ignored.
- Zero-length and saturation:
  - num_items_i = 0 → CLEAR, BINARIZE, OUTPUT with items_o = 0.
  - CounterWidth = 8, num_items_i = 130 → sat_o rises on the 128th handshake and stays high until the next start.
- Abort: abort_i at 3rd handshake of a 10-item job → one clr pulse next cycle, IDLE, items_o = 3, no binarize, no res_valid_o.
- Async reset mid-ACCUM: rst_i asserted between clock edges → all outputs 0 immediately; a subsequent 2-item job completes normally.
